// File: rtl/dmem_access_unit_if.sv
// Request/response and memory bus bundle for dmem_access_unit.
// slave: the access unit; master: the pipeline stage plus the data memory.
interface dmem_access_unit_if #(
  parameter int WORD_LEN = 16
) ();
  logic                req;
  logic [1:0]          op;
  logic [WORD_LEN-1:0] addr;
  logic [WORD_LEN-1:0] wdata;
  logic                ready;
  logic                done;
  logic [WORD_LEN-1:0] rdata;
  logic                err;
  logic                mem_re;
  logic                mem_we;
  logic [WORD_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;

  modport slave (
    input  req, op, addr, wdata, mem_rdata,
    output ready, done, rdata, err, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, op, addr, wdata, mem_rdata,
    input  ready, done, rdata, err, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store initiator between the MEM stage and the big-endian word memory.
// LH/LB/SH take one memory cycle; SB does read-modify-write over two cycles.
// Optional macro DMEM_MISALIGN_TRAP_EN: odd-address LH/SH are rejected with
// err/done instead of accessing the aligned word.
module dmem_access_unit #(
  parameter int WORD_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_unit_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;
  typedef enum logic [1:0] {OP_LH, OP_LB, OP_SH, OP_SB} op_t;

  state_t              state_q, state_d;
  op_t                 op_q;
  logic [WORD_LEN-1:0] addr_q, wdata_q, merged_q, rdata_q;
  logic                err_q;

  logic [WORD_LEN-1:0] word_addr;
  logic [7:0]          sel_byte;
  logic [WORD_LEN-1:0] merged_d;
  logic                misalign;

  logic                ready_c, done_c, err_c, re_c, we_c;
  logic [WORD_LEN-1:0] maddr_c, mwdata_c;

  assign word_addr = {addr_q[WORD_LEN-1:1], 1'b0};

`ifdef DMEM_MISALIGN_TRAP_EN
  // Halfword ops have op[0]=0; an odd address on those is trapped.
  assign misalign = bus.addr[0] & ~bus.op[0];
`else
  assign misalign = 1'b0;
`endif

  // Byte lane selection and store-byte merge on the word read this cycle
  always_comb begin
    sel_byte = addr_q[0] ? bus.mem_rdata[7:0] : bus.mem_rdata[WORD_LEN-1 -: 8];
    merged_d = bus.mem_rdata;
    if (addr_q[0]) merged_d[7:0] = wdata_q[7:0];
    else           merged_d[WORD_LEN-1 -: 8] = wdata_q[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and state-decoded bus outputs
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;
    re_c     = 1'b0;
    we_c     = 1'b0;
    maddr_c  = '0;
    mwdata_c = '0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req) state_d = misalign ? DONE : ACCESS;
      end
      ACCESS: begin
        re_c    = 1'b1;
        maddr_c = word_addr;
        if (op_q == OP_SH) begin
          we_c     = 1'b1;
          mwdata_c = wdata_q;
        end
        state_d = (op_q == OP_SB) ? MERGE : DONE;
      end
      MERGE: begin
        we_c     = 1'b1;
        maddr_c  = word_addr;
        mwdata_c = merged_q;
        state_d  = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        err_c   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load result and merged store word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_LH;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            op_q    <= op_t'(bus.op);
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            err_q   <= misalign;
          end
        end
        ACCESS: begin
          case (op_q)
            OP_LH:   rdata_q  <= bus.mem_rdata;
            OP_LB:   rdata_q  <= {{(WORD_LEN-8){sel_byte[7]}}, sel_byte};
            OP_SB:   merged_q <= merged_d;
            default: ;
          endcase
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready_c;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.rdata     = rdata_q;
  assign bus.mem_re    = re_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = maddr_c;
  assign bus.mem_wdata = mwdata_c;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit against a transaction-level model:
// a byte-array memory plus per-transaction expected cycle outputs.
module tb_dmem_access_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_access_unit_if #(.WORD_LEN(W)) bus ();
  dmem_access_unit #(.WORD_LEN(W)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Memory seen by the DUT and the reference copy, 512 bytes, big-endian words
  logic [7:0] dut_mem [0:511];
  logic [7:0] ref_mem [0:511];

  assign bus.mem_rdata = {dut_mem[{bus.mem_addr[8:1], 1'b0}],
                          dut_mem[{bus.mem_addr[8:1], 1'b1}]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      dut_mem[{bus.mem_addr[8:1], 1'b0}] <= bus.mem_wdata[15:8];
      dut_mem[{bus.mem_addr[8:1], 1'b1}] <= bus.mem_wdata[7:0];
    end
  end

  int tests = 0;
  int fails = 0;

  logic        e_ready, e_done, e_err, e_re, e_we;
  logic [15:0] e_maddr, e_mwdata, e_rdata;
  logic        chk_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every cycle, mid-cycle, against the model's expected outputs
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready",     16'(bus.ready),  16'(e_ready));
      chk("done",      16'(bus.done),   16'(e_done));
      chk("err",       16'(bus.err),    16'(e_err));
      chk("mem_re",    16'(bus.mem_re), 16'(e_re));
      chk("mem_we",    16'(bus.mem_we), 16'(e_we));
      chk("mem_addr",  bus.mem_addr,    e_maddr);
      chk("mem_wdata", bus.mem_wdata,   e_mwdata);
      chk("rdata",     bus.rdata,       e_rdata);
    end
  end

  task automatic set_idle();
    e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_re = 1'b0; e_we = 1'b0;
    e_maddr = '0;   e_mwdata = '0;
  endtask

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return {ref_mem[{a[8:1], 1'b0}], ref_mem[{a[8:1], 1'b1}]};
  endfunction

  function automatic logic [15:0] dut_word(input logic [15:0] a);
    return {dut_mem[{a[8:1], 1'b0}], dut_mem[{a[8:1], 1'b1}]};
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] w);
    dut_mem[{a[8:1], 1'b0}] = w[15:8]; dut_mem[{a[8:1], 1'b1}] = w[7:0];
    ref_mem[{a[8:1], 1'b0}] = w[15:8]; ref_mem[{a[8:1], 1'b1}] = w[7:0];
  endtask

  // Noise on the request side while busy; the unit must ignore it
  task automatic noise();
    bus.req   = 1'($urandom_range(0, 1));
    bus.op    = 2'($urandom);
    bus.addr  = 16'($urandom_range(0, 511));
    bus.wdata = 16'($urandom);
  endtask

  // One transaction; all timing below is driven at posedge+1
  task automatic run(input logic [1:0] op, input logic [15:0] a,
                     input logic [15:0] wd, input bit abort_merge);
    logic [15:0] wa, old, nw;
    logic [7:0]  b;
    bit          mis;
    wa  = {a[15:1], 1'b0};
    old = ref_word(a);
    mis = TRAP && !op[0] && a[0];
    b   = a[0] ? old[7:0] : old[15:8];
    nw  = a[0] ? {old[15:8], wd[7:0]} : {wd[7:0], old[7:0]};

    @(posedge clk); #1;
    bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
    set_idle();

    @(posedge clk); #1;            // accepted
    noise();
    if (mis) begin
      e_ready = 1'b0; e_done = 1'b1; e_err = 1'b1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      set_idle();
    end else begin
      e_ready  = 1'b0;
      e_re     = 1'b1;
      e_maddr  = wa;
      e_we     = (op == 2'b10);
      e_mwdata = (op == 2'b10) ? wd : 16'h0000;

      @(posedge clk); #1;          // end of the read cycle
      case (op)
        2'b00: e_rdata = old;
        2'b01: e_rdata = {{8{b[7]}}, b};
        2'b10: begin ref_mem[{wa[8:1], 1'b0}] = wd[15:8]; ref_mem[{wa[8:1], 1'b1}] = wd[7:0]; end
        default: ;
      endcase

      if (op == 2'b11) begin
        e_re = 1'b0; e_we = 1'b1; e_maddr = wa; e_mwdata = nw;
        noise();
        if (abort_merge) begin
          @(negedge clk); #1;
          rst = 1'b0;
          bus.req = 1'b0;
          set_idle();
          e_rdata = '0;
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst = 1'b1;
          chk("abort_mem", dut_word(a), ref_word(a));
          return;
        end
        @(posedge clk); #1;        // merged word written
        ref_mem[{wa[8:1], 1'b0}] = nw[15:8];
        ref_mem[{wa[8:1], 1'b1}] = nw[7:0];
      end

      e_re = 1'b0; e_we = 1'b0; e_maddr = '0; e_mwdata = '0;
      e_done = 1'b1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      set_idle();
    end
    chk("mem_word", dut_word(a), ref_word(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      dut_mem[i] = v;
      ref_mem[i] = v;
    end
    bus.req = 1'b1; bus.op = 2'b11; bus.addr = 16'h0010; bus.wdata = 16'h00AB;
    set_idle();
    e_rdata = '0;
    chk_on  = 1'b1;

    // Reset held with a pending request: idle outputs, no memory activity
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem", dut_word(16'h0010), ref_word(16'h0010));
    bus.req = 1'b0;
    rst = 1'b1;

    poke(16'h0010, 16'hBEEF);
    run(2'b00, 16'h0010, 16'h0000, 1'b0);
    chk("lh_lit", bus.rdata, 16'hBEEF);

    poke(16'h0010, 16'h12F0);
    run(2'b01, 16'h0011, 16'h0000, 1'b0);
    chk("lb_odd_lit", bus.rdata, 16'hFFF0);
    run(2'b01, 16'h0010, 16'h0000, 1'b0);
    chk("lb_even_lit", bus.rdata, 16'h0012);

    poke(16'h0020, 16'h1234);
    run(2'b11, 16'h0021, 16'h00AB, 1'b0);
    chk("sb_mem_lit", dut_word(16'h0020), 16'h12AB);
    chk("sb_keeps_rdata", bus.rdata, 16'h0012);
    run(2'b00, 16'h0020, 16'h0000, 1'b0);
    chk("lh_after_sb_lit", bus.rdata, 16'h12AB);

    poke(16'h0002, 16'h5555);
    run(2'b10, 16'h0003, 16'hA5C3, 1'b0);
    chk("sh_odd_mem_lit", dut_word(16'h0002), TRAP ? 16'h5555 : 16'hA5C3);
    chk("sh_keeps_rdata", bus.rdata, 16'h12AB);

    poke(16'h0030, 16'h7788);
    run(2'b11, 16'h0030, 16'h0011, 1'b1);
    chk("abort_mem_lit", dut_word(16'h0030), 16'h7788);
    chk("abort_rdata_lit", bus.rdata, 16'h0000);

    for (int n = 0; n < 300; n++) begin
      run(2'($urandom), 16'($urandom_range(0, 511)), 16'($urandom),
          ($urandom_range(0, 19) == 0));
    end

    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store initiator between the MEM pipeline stage and the word-wide data memory (two 8-bit cells per 16-bit word, big-endian, even-aligned, combinational read, write on posedge). Accepts one load or store per request over a ready/req handshake, drives memory read/write strobes, performs read-modify-write for byte stores, and returns sign-extended load data with a one-cycle done pulse. The hazard unit stalls the pipeline while `ready` is low.

## Interface
- `WORD_LEN`, 16, data and address width; matches the memory word.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `req`  input  1  request valid; sampled only when `ready`=1.
- `op`  input  2  00 LH (halfword load), 01 LB (signed byte load), 10 SH (halfword store), 11 SB (byte store).
- `addr`  input  WORD_LEN  byte address.
- `wdata`  input  WORD_LEN  store data; SB uses `wdata[7:0]`.
- `ready`  output  1  unit idle, request accepted this cycle if `req`=1.
- `done`  output  1  one-cycle pulse, access complete.
- `rdata`  output  WORD_LEN  load result, valid from `done` until the next load's `done`.
- `err`  output  1  misaligned-access pulse (see Configuration).
- `mem_re`  output  1  memory read enable.
- `mem_we`  output  1  memory write enable.
- `mem_addr`  output  WORD_LEN  memory address, always even.
- `mem_wdata`  output  WORD_LEN  memory write data.
- `mem_rdata`  input  WORD_LEN  memory read data (combinational from `mem_addr`).

## Operation
- States: IDLE, ACCESS, MERGE, DONE.
- IDLE: `ready`=1. On `req`=1, register `op`, `addr`, `wdata`; go ACCESS.
- ACCESS: `mem_addr`={addr[WORD_LEN-1:1],0}, `mem_re`=1. LH: capture `mem_rdata` into `rdata`. LB: select byte (addr[0]=0 -> high byte [15:8], 1 -> low byte [7:0]), sign-extend into `rdata`. SH: `mem_we`=1, `mem_wdata`=wdata. SB: capture `mem_rdata`, replace selected byte with wdata[7:0], go MERGE. All others go DONE.
- MERGE (SB only): `mem_we`=1, `mem_wdata`=merged word, same `mem_addr`; go DONE.
- DONE: `done`=1, `ready`=0; go IDLE.
- `mem_we`/`mem_re` are 0 in IDLE and DONE; never both asserted with `mem_we` outside ACCESS(SH)/MERGE.
- `mem_addr`, `mem_wdata` are 0 in IDLE and DONE.
- Stores never modify `rdata`.

## Timing
- Reset (asynchronous, `rst`=0): state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Reset mid-access aborts immediately; an SB in MERGE whose edge has not occurred does not write.
- Request accepted at edge N: ACCESS during cycle N+1; LH/LB/SH `done` during cycle N+2; SB MERGE during N+2, memory written at edge N+3, `done` during N+3.
- SH memory write occurs at edge N+2.
- Throughput: next request accepted at earliest in the cycle after `done` (IDLE).
- `req` while `ready`=0 is ignored; requester holds `req` until it sees `ready`=1 at an edge.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: LH/SH with addr[0]=1 is not performed; accept goes directly to DONE with `done`=1 and `err`=1 in the same cycle, no `mem_re`/`mem_we`, `rdata` unchanged.
- Undefined: `err` tied 0; halfword accesses ignore addr[0] (access the aligned word containing the byte).

## Test plan
- Reset: hold `rst`=0 with `req`=1 -> `ready`=1, all other outputs 0, no memory activity.
- LH addr 0x0010, memory word 0xBEEF -> `done` two cycles after accept, `rdata`=0xBEEF.
- LB addr 0x0011 on word 0x12F0 -> `rdata`=0xFFF0; LB addr 0x0010 -> `rdata`=0x0012.
- SB addr 0x0021, wdata 0x00AB, word 0x1234 -> one read cycle, write of 0x12AB at edge N+3, `done` cycle N+3; subsequent LH returns 0x12AB.
- SH addr 0x0003: with `DMEM_MISALIGN_TRAP_EN` -> `err`=`done`=1, memory unchanged; without -> word at 0x0002 written.
- Assert `rst`=0 during SB MERGE -> state IDLE at once, memory word unchanged, `done` never pulses.
